// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared types for the immediate-extraction stage.
//   XLEN_DEFAULT : default datapath width for RV64.
//   imm_type_t   : immediate format selector. The base I/S/B/U/J codes keep
//                  their historical encodings; IMM_Z (CSR zimm) and IMM_SH
//                  (shift amount) were added above them. Code 3'd7 is unused
//                  and decodes to a zero immediate.
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN_DEFAULT = 64;

    typedef enum logic [2:0] {
        IMM_I  = 3'd0,
        IMM_S  = 3'd1,
        IMM_B  = 3'd2,
        IMM_U  = 3'd3,
        IMM_J  = 3'd4,
        IMM_Z  = 3'd5,
        IMM_SH = 3'd6
    } imm_type_t;

endpackage

// File: rtl/imm_gen_core.sv
// ----------------------------------------------------------------------------
// imm_gen_core
// Purely combinational immediate format mux.
// Ports:
//   instr_i    in  32    raw instruction word
//   imm_type_i in  3     immediate format selector (imm_type_t encoding)
//   imm_o      out XLEN  extended immediate (0 for unlisted / illegal cases)
//   err_o      out 1     unlisted type, or RV32 shamt with instr[25] set
// ----------------------------------------------------------------------------
module imm_gen_core
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]                   instr_i,
    input  logic [$bits(imm_type_t)-1:0]  imm_type_i,
    output logic [XLEN-1:0]               imm_o,
    output logic                          err_o
);

    // Every format fits in 32 bits, so the 32-bit result is built first and
    // then widened by a signed cast. Zero-extended formats have bit 31 clear,
    // so the same cast leaves them zero-extended.
    logic signed [31:0] imm32;

    // Opcode bits never contribute to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr_i[6:0];

    // NOTE: every output of this block gets a default before the case, so no
    // path through it can leave a value unassigned and infer a latch.
    always_comb begin
        imm32 = '0;
        err_o = 1'b0;
        case (imm_type_t'(imm_type_i))
            IMM_I:  imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:  imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:  imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                             instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:  imm32 = {instr_i[31:12], 12'b0};
            IMM_J:  imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                             instr_i[20], instr_i[30:21], 1'b0};
            IMM_Z:  imm32 = {27'b0, instr_i[19:15]};
            IMM_SH: begin
                if (XLEN == 64) begin
                    imm32 = {26'b0, instr_i[25:20]};
                end else if (instr_i[25]) begin
                    // A 6-bit shift amount is illegal on RV32.
                    err_o = 1'b1;
                end else begin
                    imm32 = {27'b0, instr_i[24:20]};
                end
            end
            default: err_o = 1'b1;
        endcase
    end

    assign imm_o = XLEN'(imm32);

endmodule

// File: rtl/imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// imm_gen_pipe
// Elastic immediate-extraction stage: imm_gen_core followed by STAGES
// valid/data register stages with a combinational ready chain (no bubble,
// one result per cycle, latency STAGES cycles when unstalled).
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   flush_i                  kills every in-flight entry and any concurrent input
//   in_valid_i / in_ready_o  request handshake
//   instr_i, imm_type_i      instruction word and immediate format
//   tag_i                    opaque sideband, returned on tag_o
//   out_valid_o / out_ready_i result handshake
//   imm_o, tag_o             extended immediate and its tag
//   err_o                    (only with IMM_ERR_EN) unlisted type / RV32 illegal shamt
// Build option: define IMM_ERR_EN to add err_o.
// ----------------------------------------------------------------------------
module imm_gen_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int STAGES = 1,
    parameter int TAG_W  = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [31:0]                   instr_i,
    input  logic [$bits(imm_type_t)-1:0]  imm_type_i,
    input  logic [TAG_W-1:0]              tag_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [XLEN-1:0]               imm_o,
    output logic [TAG_W-1:0]              tag_o
`ifdef IMM_ERR_EN
    ,
    output logic                          err_o
`endif
);

    logic [XLEN-1:0] core_imm;
    logic            core_err;

    imm_gen_core #(.XLEN(XLEN)) u_core (
        .instr_i    (instr_i),
        .imm_type_i (imm_type_i),
        .imm_o      (core_imm),
        .err_o      (core_err)
    );

    // Stage k state; stage STAGES-1 drives the outputs.
    logic [STAGES-1:0] valid_q, valid_d;
    logic [XLEN-1:0]   imm_q [STAGES];
    logic [XLEN-1:0]   imm_d [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [TAG_W-1:0]  tag_d [STAGES];
    logic [STAGES-1:0] err_q, err_d;

    // What each stage would load: the core for stage 0, else the stage before.
    logic [STAGES-1:0] src_valid;
    logic [XLEN-1:0]   src_imm [STAGES];
    logic [TAG_W-1:0]  src_tag [STAGES];
    logic [STAGES-1:0] src_err;

    // ready[k]: stage k may load this cycle. ready[STAGES] is the consumer.
    logic [STAGES:0]   ready;

    always_comb begin
        ready[STAGES] = out_ready_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ready[k] = !valid_q[k] || ready[k+1];
        end

        src_valid[0] = in_valid_i;
        src_imm[0]   = core_imm;
        src_tag[0]   = tag_i;
        src_err[0]   = core_err;
        for (int k = 1; k < STAGES; k++) begin
            src_valid[k] = valid_q[k-1];
            src_imm[k]   = imm_q[k-1];
            src_tag[k]   = tag_q[k-1];
            src_err[k]   = err_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            // Flush overrides both new arrivals and held entries.
            valid_d[k] = flush_i ? 1'b0 : (ready[k] ? src_valid[k] : valid_q[k]);
            // Data only moves with a valid entry, so an idle or held output
            // keeps its last value.
            if (ready[k] && src_valid[k]) begin
                imm_d[k] = src_imm[k];
                tag_d[k] = src_tag[k];
                err_d[k] = src_err[k];
            end else begin
                imm_d[k] = imm_q[k];
                tag_d[k] = tag_q[k];
                err_d[k] = err_q[k];
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every stage
    // samples the pre-edge value of the stage before it.
    // NOTE: the data registers are reset too (not just the valids) because
    // imm_o/tag_o are observable and must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                imm_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            for (int k = 0; k < STAGES; k++) begin
                imm_q[k] <= imm_d[k];
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign in_ready_o  = ready[0];
    assign out_valid_o = valid_q[STAGES-1];
    assign imm_o       = imm_q[STAGES-1];
    assign tag_o       = tag_q[STAGES-1];

`ifdef IMM_ERR_EN
    assign err_o = err_q[STAGES-1];
`else
    logic unused_err;
    assign unused_err = ^err_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;
    import riscv_pkg::*;

`ifdef IMM_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] imm;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  ty;
        logic [63:0] imm;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    // DUT a: XLEN=64, STAGES=2
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_instr;
    logic [2:0]  a_type;
    logic [4:0]  a_tag, a_tag_o;
    logic [63:0] a_imm;
    logic        a_err;
    // DUT b: XLEN=32, STAGES=1
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_instr;
    logic [2:0]  b_type;
    logic [4:0]  b_tag, b_tag_o;
    logic [31:0] b_imm;
    logic        b_err;

    imm_gen_pipe #(.XLEN(64), .STAGES(2), .TAG_W(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush_i(a_flush),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .instr_i(a_instr), .imm_type_i(a_type), .tag_i(a_tag),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
        .imm_o(a_imm), .tag_o(a_tag_o)
`ifdef IMM_ERR_EN
        , .err_o(a_err)
`endif
    );

    imm_gen_pipe #(.XLEN(32), .STAGES(1), .TAG_W(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush_i(b_flush),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .instr_i(b_instr), .imm_type_i(b_type), .tag_i(b_tag),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
        .imm_o(b_imm), .tag_o(b_tag_o)
`ifdef IMM_ERR_EN
        , .err_o(b_err)
`endif
    );

`ifndef IMM_ERR_EN
    assign a_err = 1'b0;
    assign b_err = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // ------------------------------------------------------------------
    // Monitors: pop expected results on every output handshake, and check
    // that a held output does not change.
    // ------------------------------------------------------------------
    logic a_held = 1'b0, b_held = 1'b0;
    exp_t a_prev, b_prev, a_e, b_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            a_held = 1'b0;
        end else begin
            if (a_out_valid && a_held) begin
                check("a_hold_imm", a_imm, a_prev.imm);
                check("a_hold_tag", 64'(a_tag_o), 64'(a_prev.tag));
            end
            if (a_out_valid && a_out_ready) begin
                if (q_a.size() == 0) begin
                    fail_now("a_unexpected_output");
                end else begin
                    a_e = q_a.pop_front();
                    check("a_imm", a_imm, a_e.imm);
                    check("a_tag", 64'(a_tag_o), 64'(a_e.tag));
`ifdef IMM_ERR_EN
                    check("a_err", 64'(a_err), 64'(a_e.err));
`endif
                end
            end
            a_held = a_out_valid && !a_out_ready;
            a_prev.imm = a_imm;
            a_prev.tag = a_tag_o;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            b_held = 1'b0;
        end else begin
            if (b_out_valid && b_held) begin
                check("b_hold_imm", 64'(b_imm), b_prev.imm);
                check("b_hold_tag", 64'(b_tag_o), 64'(b_prev.tag));
            end
            if (b_out_valid && b_out_ready) begin
                if (q_b.size() == 0) begin
                    fail_now("b_unexpected_output");
                end else begin
                    b_e = q_b.pop_front();
                    check("b_imm", 64'(b_imm), b_e.imm);
                    check("b_tag", 64'(b_tag_o), 64'(b_e.tag));
`ifdef IMM_ERR_EN
                    check("b_err", 64'(b_err), 64'(b_e.err));
`endif
                end
            end
            b_held = b_out_valid && !b_out_ready;
            b_prev.imm = 64'(b_imm);
            b_prev.tag = b_tag_o;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: present a request, wait (bounded) for acceptance,
    // record the expectation, leave in_valid asserted for back-to-back use.
    // ------------------------------------------------------------------
    task automatic send_a(input vec_t v, input logic [4:0] tag);
        bit done = 0;
        a_in_valid = 1'b1; a_instr = v.instr; a_type = v.ty; a_tag = tag;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (a_in_ready) begin
                q_a.push_back('{imm: v.imm, tag: tag, err: v.err});
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) fail_now("a_accept_timeout");
    endtask

    task automatic send_b(input vec_t v, input logic [4:0] tag);
        bit done = 0;
        b_in_valid = 1'b1; b_instr = v.instr; b_type = v.ty; b_tag = tag;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (b_in_ready) begin
                q_b.push_back('{imm: v.imm, tag: tag, err: v.err});
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) fail_now("b_accept_timeout");
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && (q_a.size() != 0 || q_b.size() != 0); n++) begin
            @(posedge clk); #1;
        end
        if (q_a.size() != 0 || q_b.size() != 0) fail_now("drain_timeout");
    endtask

    vec_t va[8];
    vec_t vb[4];

    initial begin
        // XLEN=64 vectors (hand-computed)
        va[0] = '{32'hFFF00093, IMM_I,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        va[1] = '{32'h800000B7, IMM_U,  64'hFFFF_FFFF_8000_0000, 1'b0};
        va[2] = '{32'h800000EF, IMM_J,  64'hFFFF_FFFF_FFF0_0000, 1'b0};
        va[3] = '{32'h03F09093, IMM_SH, 64'd63,                  1'b0};
        va[4] = '{32'h000F8073, IMM_Z,  64'd31,                  1'b0};
        va[5] = '{32'hFE112E23, IMM_S,  64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        va[6] = '{32'hFE000EE3, IMM_B,  64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        va[7] = '{32'hFFFFFFFF, 3'd7,   64'd0,                   ERR_EN};
        // XLEN=32 vectors
        vb[0] = '{32'h800000B7, IMM_U,  64'h8000_0000, 1'b0};
        vb[1] = '{32'h03F09093, IMM_SH, 64'd0,         ERR_EN};
        vb[2] = '{32'h01F09093, IMM_SH, 64'd31,        1'b0};
        vb[3] = '{32'h800000EF, IMM_J,  64'hFFF0_0000, 1'b0};

        a_flush = 0; a_in_valid = 0; a_out_ready = 1; a_instr = 0; a_type = 0; a_tag = 0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 1; b_instr = 0; b_type = 0; b_tag = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_imm", a_imm, 64'd0);
        check("rst_a_tag", 64'(a_tag_o), 64'd0);
        check("rst_a_in_ready", 64'(a_in_ready), 64'd1);
        check("rst_b_valid", 64'(b_out_valid), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: STAGES=2 on a, STAGES=1 on b
        send_a(va[0], 5'd1);
        a_in_valid = 0;
        check("a_lat_edge1", 64'(a_out_valid), 64'd0);
        @(posedge clk); #1;
        check("a_lat_edge2", 64'(a_out_valid), 64'd1);
        send_b(vb[0], 5'd2);
        b_in_valid = 0;
        check("b_lat_edge1", 64'(b_out_valid), 64'd1);
        drain();

        // All formats back to back
        for (int i = 0; i < 8; i++) send_a(va[i], 5'(i + 3));
        a_in_valid = 0;
        for (int i = 0; i < 4; i++) send_b(vb[i], 5'(i + 12));
        b_in_valid = 0;
        drain();

        // Backpressure: consumer stalls 3 cycles during a 10-entry stream
        begin
            int t = 0;
            a_out_ready = 0;
            for (int cyc = 0; cyc < 60 && t < 10; cyc++) begin
                a_out_ready = (cyc >= 3);
                a_in_valid = 1; a_type = IMM_I; a_tag = 5'(t);
                a_instr = {12'(t), 20'h00093};
                @(negedge clk);
                if (cyc == 1) check("a_in_ready_one_entry", 64'(a_in_ready), 64'd1);
                if (cyc == 2) check("a_in_ready_full", 64'(a_in_ready), 64'd0);
                if (a_in_ready) begin
                    q_a.push_back('{imm: 64'(t), tag: 5'(t), err: 1'b0});
                    t++;
                end
                @(posedge clk); #1;
            end
            a_in_valid = 0; a_out_ready = 1;
            drain();
        end

        // Flush: tag 20 delivered in the flush cycle, 21 in flight and the
        // concurrent 22 must never appear.
        send_a(va[1], 5'd20);
        send_a(va[2], 5'd21);
        a_tag = 5'd22; a_instr = va[3].instr; a_type = va[3].ty; a_flush = 1;
        @(posedge clk); #1;
        a_flush = 0; a_in_valid = 0;
        check("a_flush_valid", 64'(a_out_valid), 64'd0);
        check("a_flush_q", 64'(q_a.size()), 64'd1);   // only tag 21 left unpopped
        q_a.delete();
        repeat (4) @(posedge clk);
        #1;
        check("a_flush_idle", 64'(a_out_valid), 64'd0);
        send_a(va[4], 5'd23);
        a_in_valid = 0;
        drain();

        // Reset mid-stream with held outputs
        a_out_ready = 0; b_out_ready = 0;
        send_a(va[5], 5'd30);
        send_a(va[6], 5'd31);
        a_in_valid = 0;
        send_b(vb[1], 5'd29);
        b_in_valid = 0;
        check("b_held_valid", 64'(b_out_valid), 64'd1);
`ifdef IMM_ERR_EN
        check("b_err_set", 64'(b_err), 64'd1);
        check("b_err_imm", 64'(b_imm), 64'd0);
`endif
        rst_n = 0;
        #1;
        check("mid_rst_a_valid", 64'(a_out_valid), 64'd0);
        check("mid_rst_a_imm", a_imm, 64'd0);
        check("mid_rst_a_tag", 64'(a_tag_o), 64'd0);
        check("mid_rst_b_valid", 64'(b_out_valid), 64'd0);
`ifdef IMM_ERR_EN
        check("mid_rst_b_err", 64'(b_err), 64'd0);
`endif
        q_a.delete(); q_b.delete();
        a_out_ready = 1; b_out_ready = 1;
        @(negedge clk) rst_n = 1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_a_valid", 64'(a_out_valid), 64'd0);
        send_a(va[0], 5'd9);
        a_in_valid = 0;
        send_b(vb[3], 5'd8);
        b_in_valid = 0;
        drain();
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
